// File: rtl/spi_msg_pkg.sv
// spi_msg_pkg
//   Shared types and constants for the SPI message sequencer.
//   - state_t       : sequencer states
//   - CMD_*         : command opcodes found in cmd[7:6]
//   - DEF_STATUS_BYTE : default byte returned by the status command
//   - byte_of()     : selects byte 0..3 (MSB first) of a 32-bit word
package spi_msg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STAT    = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_DATA = 3'd4,
    WR_DATA = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  localparam logic [1:0] CMD_STATUS = 2'b00;
  localparam logic [1:0] CMD_RSVD   = 2'b01;
  localparam logic [1:0] CMD_READ   = 2'b10;
  localparam logic [1:0] CMD_WRITE  = 2'b11;

  localparam logic [7:0] DEF_STATUS_BYTE = 8'h5A;

  // Byte 0 is the most significant byte.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_msg_word_shift.sv
// spi_msg_word_shift
//   32-bit MSB-first byte assembler / disassembler with a 2-bit byte index.
//   Write path: each shift pushes a byte in at the bottom and bumps the index.
//   Read path : load captures a whole word, adv steps the index, next_byte
//               presents the byte after the current index.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr             reset byte index only (word kept)
//   load/load_word  capture a full word, index to 0
//   shift/shift_byte  shift a byte in MSB-first, index + 1
//   adv             index + 1 without touching the word
//   word, idx       current word and byte index
//   next_byte       byte at index idx+1 of word
module spi_msg_word_shift
  import spi_msg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        shift,
  input  logic [7:0]  shift_byte,
  input  logic        adv,
  output logic [31:0] word,
  output logic [1:0]  idx,
  output logic [7:0]  next_byte
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load) begin
      word <= load_word;
      idx  <= '0;
    end else if (shift) begin
      word <= {word[23:0], shift_byte};
      idx  <= idx + 2'd1;
    end else if (adv) begin
      idx <= idx + 2'd1;
    end
  end

  assign next_byte = byte_of(word, idx + 2'd1);

endmodule

// File: rtl/spi_msg_ctrl.sv
// spi_msg_ctrl
//   Message sequencer between a byte-level SPI slave and a 32-bit register
//   file. Decodes the command byte, answers status, runs 4-byte MSB-first
//   register reads/writes and feeds the slave its next MISO byte.
// Handshakes:
//   rxValid   : one-cycle pulse, rxData valid in that cycle only.
//   txLoad    : one-cycle pulse, txData holds the new byte from then on.
//   regRd     : one-cycle request; regRdValid is a one-cycle acknowledge with
//               regRdData, accepted from the regRd cycle up to RD_TIMEOUT
//               cycles later; anything later is ignored.
//   regWr     : one-cycle strobe, regAddr/regWrData valid that cycle.
// Ports: sysClk, usrResetNot (sync active-low), ssActive, rxValid, rxData,
//   txData, txLoad, regAddr, regWrData, regWr, regRd, regRdData, regRdValid,
//   busy, errCnt, stateDbg (current state encoding for debug).
// Build option: SPI_MSG_CTRL_ERRCNT_EN enables the saturating error counter
//   on errCnt (reserved command, abort while busy, read timeout); otherwise
//   errCnt is constant 0.
module spi_msg_ctrl
  import spi_msg_pkg::*;
#(
  parameter logic [7:0] STATUS_BYTE = DEF_STATUS_BYTE,
  parameter int         REG_AW      = 4,
  parameter int         RD_TIMEOUT  = 4,
  parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
  input  logic              sysClk,
  input  logic              usrResetNot,
  input  logic              ssActive,
  input  logic              rxValid,
  input  logic [7:0]        rxData,
  output logic [7:0]        txData,
  output logic              txLoad,
  output logic [REG_AW-1:0] regAddr,
  output logic [31:0]       regWrData,
  output logic              regWr,
  output logic              regRd,
  input  logic [31:0]       regRdData,
  input  logic              regRdValid,
  output logic              busy,
  output logic [7:0]        errCnt,
  output logic [2:0]        stateDbg
);

  localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(RD_TIMEOUT);

  state_t        state;
  logic [TW-1:0] tmr;     // cycles since regRd while in RD_WAIT
  logic          rd_err;  // current read timed out: all bytes are ERR_BYTE

  logic          ws_clr, ws_load, ws_shift, ws_adv;
  logic [1:0]    ws_idx;
  logic [7:0]    ws_next;
  logic          rd_accept, rd_timeout, cmd_seen;

  assign cmd_seen   = ssActive && (state == IDLE) && rxValid;
  assign rd_accept  = ssActive && regRdValid && ((state == RD_REQ) || (state == RD_WAIT));
  assign rd_timeout = ssActive && !regRdValid && (state == RD_WAIT) && (tmr == TMAX);

  assign ws_clr   = (cmd_seen && (rxData[7:6] == CMD_WRITE)) || rd_timeout;
  assign ws_load  = rd_accept;
  assign ws_shift = ssActive && (state == WR_DATA) && rxValid;
  assign ws_adv   = ssActive && (state == RD_DATA) && rxValid;

  spi_msg_word_shift u_shift (
    .clk        (sysClk),
    .rst_n      (usrResetNot),
    .clr        (ws_clr),
    .load       (ws_load),
    .load_word  (regRdData),
    .shift      (ws_shift),
    .shift_byte (rxData),
    .adv        (ws_adv),
    .word       (regWrData),
    .idx        (ws_idx),
    .next_byte  (ws_next)
  );

  always_ff @(posedge sysClk) begin
    if (!usrResetNot) begin
      state   <= IDLE;
      txData  <= 8'h00;
      txLoad  <= 1'b0;
      regAddr <= '0;
      regWr   <= 1'b0;
      regRd   <= 1'b0;
      tmr     <= '0;
      rd_err  <= 1'b0;
    end else begin
      txLoad <= 1'b0;
      regWr  <= 1'b0;
      regRd  <= 1'b0;
      if (!ssActive) begin
        // Abort wins over any byte arriving in the same cycle.
        state  <= IDLE;
        txData <= 8'h00;
        txLoad <= (state != IDLE);
      end else begin
        case (state)
          IDLE: if (rxValid) begin
            case (rxData[7:6])
              CMD_STATUS: begin
                state  <= STAT;
                txData <= STATUS_BYTE;
                txLoad <= 1'b1;
              end
              CMD_READ: begin
                state   <= RD_REQ;
                regRd   <= 1'b1;
                regAddr <= rxData[REG_AW-1:0];
              end
              CMD_WRITE: begin
                state   <= WR_DATA;
                regAddr <= rxData[REG_AW-1:0];
              end
              default: begin
                state  <= DRAIN;
                txData <= 8'h00;
                txLoad <= 1'b1;
              end
            endcase
          end
          STAT: if (rxValid) begin
            state  <= IDLE;
            txData <= 8'h00;
            txLoad <= 1'b1;
          end
          RD_REQ: begin
            if (regRdValid) begin
              state  <= RD_DATA;
              rd_err <= 1'b0;
              txData <= regRdData[31:24];
              txLoad <= 1'b1;
            end else begin
              state <= RD_WAIT;
              tmr   <= TW'(1);
            end
          end
          RD_WAIT: begin
            if (regRdValid) begin
              state  <= RD_DATA;
              rd_err <= 1'b0;
              txData <= regRdData[31:24];
              txLoad <= 1'b1;
            end else if (rd_timeout) begin
              state  <= RD_DATA;
              rd_err <= 1'b1;
              txData <= ERR_BYTE;
              txLoad <= 1'b1;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          RD_DATA: if (rxValid) begin
            txLoad <= 1'b1;
            if (ws_idx == 2'd3) begin
              state  <= IDLE;
              txData <= 8'h00;
            end else begin
              txData <= rd_err ? ERR_BYTE : ws_next;
            end
          end
          WR_DATA: if (rxValid && (ws_idx == 2'd3)) begin
            // Fourth byte shifts in on this edge; word is complete with regWr.
            state <= IDLE;
            regWr <= 1'b1;
          end
          DRAIN: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy     = (state != IDLE);
  assign stateDbg = state;

`ifdef SPI_MSG_CTRL_ERRCNT_EN
  logic       err_evt;
  logic [7:0] err_q;

  assign err_evt = (!ssActive && (state != IDLE)) ||
                   (cmd_seen && (rxData[7:6] == CMD_RSVD)) ||
                   rd_timeout;

  always_ff @(posedge sysClk) begin
    if (!usrResetNot) begin
      err_q <= 8'h00;
    end else if (err_evt && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'h01;
    end
  end

  assign errCnt = err_q;
`else
  assign errCnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_msg_ctrl.sv
// tb_spi_msg_ctrl
//   Message-level bench for spi_msg_ctrl. Inputs are driven and outputs
//   sampled on the falling edge. Each message task derives the expected
//   MISO byte stream, register strobes and error count from the message
//   rules and compares them with what the DUT produces.
module tb_spi_msg_ctrl;

  localparam logic [7:0] STATUS_BYTE = 8'h5A;
  localparam logic [7:0] ERR_BYTE    = 8'hEE;
  localparam int         RD_TIMEOUT  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        sysClk = 1'b0;
  logic        usrResetNot = 1'b0;
  logic        ssActive = 1'b0;
  logic        rxValid = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic [7:0]  txData;
  logic        txLoad;
  logic [3:0]  regAddr;
  logic [31:0] regWrData;
  logic        regWr;
  logic        regRd;
  logic [31:0] regRdData = 32'h0;
  logic        regRdValid = 1'b0;
  logic        busy;
  logic [7:0]  errCnt;
  logic [2:0]  stateDbg;

  always #5 sysClk = ~sysClk;

  spi_msg_ctrl dut (
    .sysClk     (sysClk),
    .usrResetNot(usrResetNot),
    .ssActive   (ssActive),
    .rxValid    (rxValid),
    .rxData     (rxData),
    .txData     (txData),
    .txLoad     (txLoad),
    .regAddr    (regAddr),
    .regWrData  (regWrData),
    .regWr      (regWr),
    .regRd      (regRd),
    .regRdData  (regRdData),
    .regRdValid (regRdValid),
    .busy       (busy),
    .errCnt     (errCnt),
    .stateDbg   (stateDbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int err_model = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bump_err();
    if (err_model < 255) err_model++;
  endtask

  task automatic check_err(input string tag);
`ifdef SPI_MSG_CTRL_ERRCNT_EN
    check(tag, {24'h0, errCnt}, err_model);
`else
    check(tag, {24'h0, errCnt}, 32'h0);
`endif
  endtask

  // Strobe monitor.
  always @(negedge sysClk) begin
    if (usrResetNot) begin
      if (regRd) rd_cnt++;
      if (regWr) wr_cnt++;
      if (regRd && regWr) both_cnt++;
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge sysClk);
    rxValid = 1'b1;
    rxData  = b;
    @(negedge sysClk);
    rxValid = 1'b0;
    rxData  = 8'($urandom);
  endtask

  // Drop slave select for one cycle; DUT must be idle afterwards.
  task automatic abort_ss(input string tag);
    ssActive = 1'b0;
    @(negedge sysClk);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_tx0"}, txData, 8'h00);
    ssActive = 1'b1;
  endtask

  task automatic msg_status();
    send_byte({2'b00, 6'($urandom)});
    check("stat_load", txLoad, 1'b1);
    check("stat_byte", txData, STATUS_BYTE);
    check("stat_busy", busy, 1'b1);
    send_byte(8'($urandom));
    check("stat_end_load", txLoad, 1'b1);
    check("stat_end_byte", txData, 8'h00);
    check("stat_end_idle", busy, 1'b0);
  endtask

  // n_abort < 4: abort before data byte n_abort; otherwise complete.
  task automatic msg_write(input logic [3:0] addr, input logic [31:0] w, input int n_abort);
    send_byte({2'b11, 2'($urandom), addr});
    check("wr_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == n_abort) begin
        abort_ss("wr_abort");
        bump_err();
        check_err("wr_abort_err");
        @(negedge sysClk);
        check("wr_abort_nowr", wr_cnt, exp_wr);
        return;
      end
      send_byte(w[8*(3-i) +: 8]);
      check("wr_tx0", txData, 8'h00);
    end
    check("wr_strobe", regWr, 1'b1);
    check("wr_addr", regAddr, addr);
    check("wr_data", regWrData, w);
    exp_wr++;
    @(negedge sysClk);
    check("wr_single", regWr, 1'b0);
    check("wr_idle", busy, 1'b0);
    check("wr_count", wr_cnt, exp_wr);
    check("wr_no_rd", rd_cnt, exp_rd);
  endtask

  // lat: cycles after the regRd cycle at which regRdValid is returned.
  task automatic msg_read(input logic [3:0] addr, input logic [31:0] w, input int lat);
    bit ok;
    int got_at;
    int exp_at;
    logic [7:0] got_b;
    ok = (lat <= RD_TIMEOUT);
    send_byte({2'b10, 2'($urandom), addr});
    check("rd_req", regRd, 1'b1);
    check("rd_addr", regAddr, addr);
    exp_rd++;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(ok ? w[8*(3-i) +: 8] : ERR_BYTE);
    exp_q.push_back(8'h00);
    exp_at = ok ? lat + 1 : RD_TIMEOUT + 1;
    got_at = -1;
    got_b  = 8'h00;
    // Bounded wait for the first data byte; a late acknowledge is still sent.
    for (int k = 0; k <= RD_TIMEOUT + 4; k++) begin
      regRdValid = (k == lat);
      regRdData  = (k == lat) ? w : 32'($urandom);
      @(negedge sysClk);
      regRdValid = 1'b0;
      if (got_at < 0 && txLoad) begin
        got_at = k + 1;
        got_b  = txData;
      end
    end
    if (!ok) bump_err();
    check("rd_first_at", got_at, exp_at);
    check("rd_byte0", got_b, exp_q.pop_front());
    check("rd_addr_hold", regAddr, addr);
    for (int i = 1; i < 5; i++) begin
      send_byte(8'($urandom));
      check("rd_load", txLoad, 1'b1);
      check("rd_byte", txData, exp_q.pop_front());
    end
    check("rd_idle", busy, 1'b0);
    check("rd_count", rd_cnt, exp_rd);
    check_err("rd_err");
  endtask

  task automatic msg_reserved(input int extra);
    send_byte({2'b01, 6'($urandom)});
    bump_err();
    check("rsv_busy", busy, 1'b1);
    check("rsv_tx0", txData, 8'h00);
    for (int i = 0; i < extra; i++) begin
      send_byte(8'($urandom));
      check("drain_busy", busy, 1'b1);
      check("drain_tx0", txData, 8'h00);
    end
    abort_ss("drain_end");
    bump_err();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge sysClk);
    check("rst_tx", txData, 8'h00);
    check("rst_txload", txLoad, 1'b0);
    check("rst_wr", regWr, 1'b0);
    check("rst_rd", regRd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", regAddr, 4'h0);
    check("rst_wdata", regWrData, 32'h0);
    check("rst_errcnt", errCnt, 8'h00);
    usrResetNot = 1'b1;
    ssActive    = 1'b1;
    @(negedge sysClk);

    // Directed cases.
    msg_status();
    msg_write(4'h0, 32'h76543210, 4);
    msg_read(4'h4, 32'hDEADBEEF, 2);
    msg_read(4'h5, 32'h12345678, RD_TIMEOUT + 3);
    msg_read(4'h6, 32'hCAFEF00D, RD_TIMEOUT);
    msg_read(4'h7, 32'h0BADF00D, 0);
    msg_write(4'h1, 32'hA5A5A5A5, 2);
    msg_status();

    // Byte arriving together with slave-select drop is dropped.
    ssActive = 1'b0;
    rxValid  = 1'b1;
    rxData   = 8'h00;
    @(negedge sysClk);
    rxValid  = 1'b0;
    ssActive = 1'b1;
    check("coinc_idle", busy, 1'b0);
    check("coinc_noload", txLoad, 1'b0);
    check_err("coinc_err");

    // Read abandoned mid-flight; its acknowledge must be ignored.
    send_byte(8'h83);
    check("rdab_req", regRd, 1'b1);
    exp_rd++;
    abort_ss("rdab");
    bump_err();
    regRdValid = 1'b1;
    regRdData  = 32'h11223344;
    @(negedge sysClk);
    regRdValid = 1'b0;
    @(negedge sysClk);
    check("rdab_noload", txLoad, 1'b0);
    check("rdab_idle", busy, 1'b0);
    check_err("rdab_err");
    msg_status();

    msg_reserved(2);
    check_err("rsv_err");

    // Randomized back-to-back traffic.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: msg_status();
        1: msg_read(4'($urandom), $urandom, $urandom_range(0, RD_TIMEOUT + 3));
        2: msg_write(4'($urandom), $urandom, $urandom_range(0, 7));
        default: msg_reserved($urandom_range(0, 1));
      endcase
      check_err("rand_err");
    end

    // Push the error counter into saturation.
    for (int n = 0; n < 300; n++) msg_reserved(0);
    check_err("sat_err");
    msg_status();

    @(negedge sysClk);
    check("no_rd_wr_overlap", both_cnt, 0);
    check("final_rd_count", rd_cnt, exp_rd);
    check("final_wr_count", wr_cnt, exp_wr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
